window_gen: RTL and testbench

Streaming sliding-window generator that feeds the SIZE×SIZE convolution datapath. It accepts a raster-scan pixel stream, one signed pixel per handshake, and keeps SIZE-1 line buffers plus a SIZE×SIZE shift window. Every valid (unpadded) SIZE×SIZE window is presented on a registered valid/ready output, in the same `[row][col]` orientation the convolution's `Kernel`/`inpMatrixI` inputs use.

---
 rtl/window_gen.sv | 123 ++++++++++++
 tb/tb_window_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen.sv
// Streaming SIZE x SIZE sliding-window generator over a raster pixel stream.
// Define WINDOW_GEN_STRIDE2_EN to emit only every other window in each direction.
module window_gen #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                                            clock,
  input  logic                                            nreset,
  input  logic                                            pix_valid,
  output logic                                            pix_ready,
  input  logic signed [WIDTH_BIT-1:0]                     pix_data,
  output logic                                            win_valid,
  input  logic                                            win_ready,
  output logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] window,
  output logic                                            frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(SIZE - 1);
`ifdef WINDOW_GEN_STRIDE2_EN
  // (n - (SIZE-1)) is even exactly when n has the same parity as SIZE-1
  localparam logic STRIDE_PAR = 1'((SIZE - 1) % 2);
`endif

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [WIDTH_BIT-1:0] lb [SIZE-1][IMG_W];
  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] sw, sw_next;
  logic [SIZE-1:0][WIDTH_BIT-1:0] newcol;
  logic accept, emit, col_last, row_last;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);

  // lb[0] holds the previous line, lb[SIZE-2] the oldest; window row 0 is oldest
  always_comb begin
    newcol = '0;
    newcol[SIZE-1] = pix_data;
    for (int unsigned r = 0; r < SIZE - 1; r++) begin
      newcol[r] = lb[SIZE-2-r][col];
    end
  end

  always_comb begin
    sw_next = sw;
    for (int unsigned r = 0; r < SIZE; r++) begin
      for (int unsigned c = 0; c < SIZE - 1; c++) begin
        sw_next[r][c] = sw[r][c+1];
      end
      sw_next[r][SIZE-1] = newcol[r];
    end
  end

  always_comb begin
    emit = accept && (row >= ROW_WIN) && (col >= COL_WIN);
`ifdef WINDOW_GEN_STRIDE2_EN
    emit = emit && (row[0] == STRIDE_PAR) && (col[0] == STRIDE_PAR);
`endif
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned k = 0; k < SIZE - 1; k++) begin
        for (int unsigned i = 0; i < IMG_W; i++) begin
          lb[k][i] <= '0;
        end
      end
    end else if (accept) begin
      lb[0][col] <= pix_data;
      for (int unsigned k = 1; k < SIZE - 1; k++) begin
        lb[k][col] <= lb[k-1][col];
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sw <= '0;
    end else if (accept) begin
      sw <= sw_next;
    end
  end

  // The output register captures the post-shift window so it includes the new pixel
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      win_valid  <= 1'b0;
      window     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && row_last && col_last;
      if (emit) begin
        win_valid <= 1'b1;
        window    <= sw_next;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen: directed frames plus randomized traffic
// checked against a frame-array reference model.
module tb_window_gen;
  localparam int S  = 3;
  localparam int WB = 8;
  localparam int IW = 4;
  localparam int IH = 4;
`ifdef WINDOW_GEN_STRIDE2_EN
  localparam int WPF     = ((IW - S) / 2 + 1) * ((IH - S) / 2 + 1);
  localparam int LAST_TL = 0;
`else
  localparam int WPF     = (IW - S + 1) * (IH - S + 1);
  localparam int LAST_TL = 5;
`endif

  typedef logic [S-1:0][S-1:0][WB-1:0] win_t;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [WB-1:0] pix_data = '0;
  logic win_valid;
  logic win_ready = 1'b1;
  win_t window;
  logic frame_done;

  int total = 0;
  int bad = 0;
  win_t got_q[$];
  win_t exp_q[$];
  int fd_cnt = 0;
  logic [WB-1:0] fr [IH][IW];
  int mr = 0;
  int mc = 0;
  bit rand_mode = 1'b0;

  window_gen #(.SIZE(S), .WIDTH_BIT(WB), .IMG_W(IW), .IMG_H(IH)) u_dut (
    .clock(clock), .nreset(nreset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .win_valid(win_valid), .win_ready(win_ready), .window(window),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Record every consumed window and every frame_done pulse
  always begin
    @(negedge clock);
    #2;
    if (nreset === 1'b1 && win_valid === 1'b1 && win_ready === 1'b1) got_q.push_back(window);
    if (nreset === 1'b1 && frame_done === 1'b1) fd_cnt++;
  end

  function automatic win_t seq_win(input int tl);
    win_t w;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        w[i][j] = WB'(tl + i * IW + j);
    return w;
  endfunction

  function automatic win_t mk_win(input int r, input int c);
    win_t w;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        w[i][j] = fr[r - (S - 1) + i][c - (S - 1) + j];
    return w;
  endfunction

  function automatic bit emits(input int r, input int c);
    bit e;
    e = (r >= S - 1) && (c >= S - 1);
`ifdef WINDOW_GEN_STRIDE2_EN
    e = e && ((r - (S - 1)) % 2 == 0) && ((c - (S - 1)) % 2 == 0);
`endif
    return e;
  endfunction

  task automatic model_accept(input logic [WB-1:0] v);
    fr[mr][mc] = v;
    if (emits(mr, mc)) exp_q.push_back(mk_win(mr, mc));
    mc++;
    if (mc == IW) begin
      mc = 0;
      mr = (mr == IH - 1) ? 0 : mr + 1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the pixel is accepted
  task automatic drive_px(input logic [WB-1:0] v);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    if (rand_mode) begin
      while ($urandom_range(0, 3) == 0) begin
        win_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
    end
    pix_valid = 1'b1;
    pix_data  = v;
    while (!acc && n < 200) begin
      if (rand_mode) win_ready = 1'($urandom_range(0, 1));
      #1;
      if (pix_ready === 1'b1) acc = 1'b1;
      @(negedge clock);
      n++;
    end
    pix_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout got=no_accept exp=accept pixel=%0d", v);
    end else begin
      model_accept(v);
    end
  endtask

  task automatic start_case();
    @(negedge clock);
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    win_ready = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL rst_win_valid got=%b exp=0", win_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rst_pix_ready got=%b exp=1", pix_ready); end
    total++; if (window !== '0) begin bad++; $display("FAIL rst_window got=%h exp=0", window); end
    nreset = 1'b1;
    mr = 0; mc = 0;
  endtask

  task automatic test_basic();
    start_case();
    for (int v = 0; v < IW * IH; v++) begin
      drive_px(WB'(v));
      if (v == 10) begin
        total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL basic_first_valid got=%b exp=1", win_valid); end
        total++; if (window !== seq_win(0)) begin bad++; $display("FAIL basic_first_win got=%h exp=%h", window, seq_win(0)); end
      end
      if (v == IW * IH - 1) begin
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL basic_fd_pulse got=%b exp=1", frame_done); end
      end
    end
    @(negedge clock);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_fd_end got=%b exp=0", frame_done); end
    drain();
    total++; if (got_q.size() != WPF) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), WPF); end
    if (got_q.size() > 0) begin
      total++; if (got_q[got_q.size()-1] !== seq_win(LAST_TL)) begin bad++; $display("FAIL basic_last got=%h exp=%h", got_q[got_q.size()-1], seq_win(LAST_TL)); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL basic_fd_count got=%0d exp=1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    start_case();
    for (int v = 0; v <= 10; v++) drive_px(WB'(v));
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd11;
    repeat (5) begin
      #1;
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL bp_pix_ready got=%b exp=0", pix_ready); end
      total++; if (win_valid !== 1'b1 || window !== seq_win(0)) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", win_valid, window, seq_win(0)); end
      @(negedge clock);
    end
    pix_valid = 1'b0;
    win_ready = 1'b1;
    for (int v = 11; v < IW * IH; v++) drive_px(WB'(v));
    drain();
    total++; if (got_q.size() != WPF || exp_q.size() != WPF) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), WPF); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    start_case();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < IW * IH; p++)
        drive_px(WB'(f * 100 + p));
    drain();
    total++; if (got_q.size() != 2 * WPF) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2 * WPF); end
    if (got_q.size() > WPF) begin
      total++; if (got_q[WPF] !== seq_win(100)) begin bad++; $display("FAIL b2b_first_f2 got=%h exp=%h", got_q[WPF], seq_win(100)); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (fd_cnt != 2) begin bad++; $display("FAIL b2b_fd_count got=%0d exp=2", fd_cnt); end
  endtask

  task automatic test_signed();
    start_case();
    for (int p = 0; p < IW * IH; p++) drive_px((p % 2 == 0) ? 8'h80 : 8'h7f);
    drain();
    total++; if (got_q.size() != WPF) begin bad++; $display("FAIL signed_count got=%0d exp=%0d", got_q.size(), WPF); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL signed_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    start_case();
    rand_mode = 1'b1;
    for (int p = 0; p < 3 * IW * IH; p++) drive_px(WB'($urandom));
    drain();
    total++; if (got_q.size() != 3 * WPF) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), 3 * WPF); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (fd_cnt != 3) begin bad++; $display("FAIL rand_fd_count got=%0d exp=3", fd_cnt); end
  endtask

  task automatic test_reset_midframe();
    start_case();
    for (int v = 0; v <= 10; v++) drive_px(WB'(v));
    win_ready = 1'b0;
    nreset = 1'b0;
    #1;
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL midrst_win_valid got=%b exp=0", win_valid); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL midrst_pix_ready got=%b exp=1", pix_ready); end
    @(negedge clock);
    nreset = 1'b1;
    win_ready = 1'b1;
    mr = 0; mc = 0;
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
    for (int v = 0; v < IW * IH; v++) drive_px(WB'(v));
    drain();
    total++; if (got_q.size() != WPF) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), WPF); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== seq_win(0)) begin bad++; $display("FAIL midrst_first got=%h exp=%h", got_q[0], seq_win(0)); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_win%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL midrst_fd_count got=%0d exp=1", fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_signed();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
